// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command controller.
// Covers FSM states, the default frame header, STATUS bit positions and frame lengths.
package alu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_GA0  = 4'd1,
      S_GA1  = 4'd2,
      S_GB0  = 4'd3,
      S_GB1  = 4'd4,
      S_GFUN = 4'd5,
      S_EXEC = 4'd6,
      S_WAIT = 4'd7,
      S_TX0  = 4'd8,
      S_TX1  = 4'd9,
      S_TX2  = 4'd10
   } state_t;

   localparam logic [7:0] HDR_DEF = 8'hCC;

   localparam int ST_ARITH = 7;
   localparam int ST_LOGIC = 6;
   localparam int ST_CMP   = 5;
   localparam int ST_SHIFT = 4;
   localparam int ST_TMO   = 3;
   localparam int ST_CARRY = 0;

   localparam int CMD_LEN = 6;
   localparam int RSP_LEN = 3;

endpackage

// File: rtl/alu_res_sel.sv
// Combinational priority select of the ALU result and response STATUS byte.
// Priority is Arith > Logic > CMP > SHIFT; all four flags are reported in STATUS.
module alu_res_sel
   import alu_ctrl_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] arith_out,
   input  logic [DATA_W-1:0] logic_out,
   input  logic [DATA_W-1:0] shift_out,
   input  logic [1:0]        cmp_out,
   input  logic              carry_out,
   input  logic              arith_flag,
   input  logic              logic_flag,
   input  logic              cmp_flag,
   input  logic              shift_flag,
   output logic [DATA_W-1:0] res,
   output logic [7:0]        status,
   output logic              any_flag
);

   // Result mux and STATUS assembly from the live ALU flags
   always_comb begin
      res      = {DATA_W{1'b0}};
      status   = 8'h00;
      any_flag = arith_flag | logic_flag | cmp_flag | shift_flag;

      status[ST_ARITH] = arith_flag;
      status[ST_LOGIC] = logic_flag;
      status[ST_CMP]   = cmp_flag;
      status[ST_SHIFT] = shift_flag;
      status[ST_CARRY] = arith_flag & carry_out;

      if (arith_flag) begin
         res = arith_out;
      end else if (logic_flag) begin
         res = logic_out;
      end else if (cmp_flag) begin
         res = {{(DATA_W-2){1'b0}}, cmp_out};
      end else if (shift_flag) begin
         res = shift_out;
      end else begin
         res = {DATA_W{1'b0}};
      end
   end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command controller: assembles a 6-byte command from RX, runs one ALU
// operation, and returns RES low, RES high and STATUS as a 3-byte response on TX.
module alu_cmd_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int         DATA_W      = 16,
   parameter logic [7:0] HDR         = HDR_DEF,
   parameter int         RES_TIMEOUT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [7:0]        RX_DATA,
   input  logic              RX_VALID,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [3:0]        ALU_FUN,
   output logic              ALU_EN,
   input  logic [DATA_W-1:0] Arith_OUT,
   input  logic [DATA_W-1:0] Logic_OUT,
   input  logic [DATA_W-1:0] SHIFT_OUT,
   input  logic [1:0]        CMP_OUT,
   input  logic              Carry_OUT,
   input  logic              Arith_Flag,
   input  logic              Logic_Flag,
   input  logic              CMP_Flag,
   input  logic              SHIFT_Flag,
   output logic [7:0]        TX_DATA,
   output logic              TX_VALID,
   input  logic              TX_READY
);

   localparam int               CNT_W   = $clog2(RES_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(RES_TIMEOUT);

   state_t              state_r, state_d;
   logic [7:0]          a_lo_r, a_hi_r, b_lo_r, b_hi_r;
   logic [CNT_W-1:0]    cnt_r, cnt_d;
   logic [DATA_W-1:0]   res_r, res_d, sel_res_s;
   logic [7:0]          status_r, status_d, sel_status_s;
   logic                any_flag_s, load_op_s, alu_en_d, tx_valid_d;
   logic [7:0]          tx_data_d;

   alu_res_sel #(.DATA_W(DATA_W)) u_res_sel (
      .arith_out  (Arith_OUT),
      .logic_out  (Logic_OUT),
      .shift_out  (SHIFT_OUT),
      .cmp_out    (CMP_OUT),
      .carry_out  (Carry_OUT),
      .arith_flag (Arith_Flag),
      .logic_flag (Logic_Flag),
      .cmp_flag   (CMP_Flag),
      .shift_flag (SHIFT_Flag),
      .res        (sel_res_s),
      .status     (sel_status_s),
      .any_flag   (any_flag_s)
   );

   // FSM state register
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_d;
      end
   end

   // Next state, result capture and registered-output next values
   always_comb begin
      state_d   = state_r;
      cnt_d     = cnt_r;
      res_d     = res_r;
      status_d  = status_r;
      load_op_s = 1'b0;

      case (state_r)
         S_IDLE: if (RX_VALID && (RX_DATA == HDR)) state_d = S_GA0; else state_d = S_IDLE;
         S_GA0:  if (RX_VALID) state_d = S_GA1;  else state_d = S_GA0;
         S_GA1:  if (RX_VALID) state_d = S_GB0;  else state_d = S_GA1;
         S_GB0:  if (RX_VALID) state_d = S_GB1;  else state_d = S_GB0;
         S_GB1:  if (RX_VALID) state_d = S_GFUN; else state_d = S_GB1;
         S_GFUN: begin
            if (RX_VALID) begin
               state_d   = S_EXEC;
               load_op_s = 1'b1;
            end else begin
               state_d   = S_GFUN;
            end
         end
         S_EXEC: begin
            state_d = S_WAIT;
            cnt_d   = {CNT_W{1'b0}};
         end
         S_WAIT: begin
            if (any_flag_s) begin
               res_d    = sel_res_s;
               status_d = sel_status_s;
               state_d  = S_TX0;
            end else if (cnt_r == TMO_CNT) begin
               res_d            = {DATA_W{1'b0}};
               status_d         = 8'h00;
               status_d[ST_TMO] = 1'b1;
               state_d          = S_TX0;
            end else begin
               cnt_d = cnt_r + CNT_W'(1);
            end
         end
         S_TX0:  if (TX_VALID && TX_READY) state_d = S_TX1;  else state_d = S_TX0;
         S_TX1:  if (TX_VALID && TX_READY) state_d = S_TX2;  else state_d = S_TX1;
         S_TX2:  if (TX_VALID && TX_READY) state_d = S_IDLE; else state_d = S_TX2;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they can be registered without a cycle of lag
      alu_en_d = (state_d == S_EXEC);
      case (state_d)
         S_TX0: begin
            tx_valid_d = 1'b1;
            tx_data_d  = res_d[7:0];
         end
         S_TX1: begin
            tx_valid_d = 1'b1;
            tx_data_d  = res_d[15:8];
         end
         S_TX2: begin
            tx_valid_d = 1'b1;
            tx_data_d  = status_d;
         end
         default: begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end
      endcase
   end

   // Shadow bytes, operand registers, result capture and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         a_lo_r   <= 8'h00;
         a_hi_r   <= 8'h00;
         b_lo_r   <= 8'h00;
         b_hi_r   <= 8'h00;
         cnt_r    <= {CNT_W{1'b0}};
         res_r    <= {DATA_W{1'b0}};
         status_r <= 8'h00;
         A        <= {DATA_W{1'b0}};
         B        <= {DATA_W{1'b0}};
         ALU_FUN  <= 4'h0;
         ALU_EN   <= 1'b0;
         TX_VALID <= 1'b0;
         TX_DATA  <= 8'h00;
      end else begin
         cnt_r    <= cnt_d;
         res_r    <= res_d;
         status_r <= status_d;
         ALU_EN   <= alu_en_d;
         TX_VALID <= tx_valid_d;
         TX_DATA  <= tx_data_d;
         // Operands change only on a completed frame so the ALU inputs stay quiet otherwise
         if (load_op_s) begin
            A       <= {a_hi_r, a_lo_r};
            B       <= {b_hi_r, b_lo_r};
            ALU_FUN <= RX_DATA[3:0];
         end
         if (RX_VALID) begin
            case (state_r)
               S_GA0:   a_lo_r <= RX_DATA;
               S_GA1:   a_hi_r <= RX_DATA;
               S_GB0:   b_lo_r <= RX_DATA;
               S_GB1:   b_hi_r <= RX_DATA;
               default: ;
            endcase
         end
      end
   end

endmodule
